xnor_unit: RTL and testbench

- Bitwise 2-input XNOR (equivalence) block for the logic-gate library. At WIDTH=1 it is a plain XNOR gate.
- Provides a combinational result path and a registered, valid-qualified result path with an all-bits-equal flag.
- Provides a saturating count of fully-equal samples for datapath comparators and self-check logic.

---
 rtl/xnor_unit.sv | 68 ++++++
 tb/tb_xnor_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/xnor_unit.sv
// Bitwise XNOR with a combinational result, a registered valid-qualified result
// with an all-bits-equal flag, and a saturating count of fully-equal samples.
module xnor_unit #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             eq_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] eq_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [WIDTH-1:0] xn_p0;
    logic             eq_p0;
    logic             run_p0;
    logic             accept_p0;

    logic [WIDTH-1:0] y_p1;
    logic             eq_p1;
    logic             vld_p1;
    logic [CNT_W-1:0] cnt_p1;

    // Stage 0: combinational equivalence
    assign xn_p0     = ~(a ^ b);
    assign eq_p0     = &xn_p0;
    assign y         = xn_p0;
    // run_p0 blocks capture on the first edge after reset is released
    assign accept_p0 = run_p0 & in_valid;

    // Stage 1: registered result and counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            y_p1   <= '0;
            eq_p1  <= 1'b0;
            cnt_p1 <= '0;
        end else begin
            run_p0 <= 1'b1;
            vld_p1 <= accept_p0;
            if (accept_p0) begin
                y_p1  <= xn_p0;
                eq_p1 <= eq_p0;
            end
            if (clr_cnt)
                cnt_p1 <= '0;
            else if (accept_p0 && eq_p0)
                cnt_p1 <= sat_inc(cnt_p1);
        end
    end

    assign y_q       = y_p1;
    assign eq_q      = eq_p1;
    assign out_valid = vld_p1;
    assign eq_cnt    = cnt_p1;

endmodule

// File: tb/tb_xnor_unit.sv
// Directed bench for xnor_unit: 1-bit gate, 8-bit word and 2-bit counter instances.
module tb_xnor_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 1-bit, default counter width
    logic       a1 = 0, b1 = 0, v1 = 0, c1 = 0;
    logic       y1, yq1, eq1, ov1;
    logic [7:0] cnt1;
    // 8-bit operands
    logic [7:0] a8 = 0, b8 = 0;
    logic       v8 = 0, c8 = 0;
    logic [7:0] y8, yq8;
    logic       eq8, ov8;
    logic [7:0] cnt8;
    // 1-bit, 2-bit counter
    logic       ac = 0, bc = 0, vc = 0, cc = 0;
    logic       yc, yqc, eqc, ovc;
    logic [1:0] cntc;

    int total = 0;
    int bad = 0;

    xnor_unit #(.WIDTH(1), .CNT_W(8)) u_d1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1), .clr_cnt(c1),
        .y(y1), .y_q(yq1), .eq_q(eq1), .out_valid(ov1), .eq_cnt(cnt1)
    );
    xnor_unit #(.WIDTH(8), .CNT_W(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(v8), .clr_cnt(c8),
        .y(y8), .y_q(yq8), .eq_q(eq8), .out_valid(ov8), .eq_cnt(cnt8)
    );
    xnor_unit #(.WIDTH(1), .CNT_W(2)) u_dc (
        .clk(clk), .rst_n(rst_n), .a(ac), .b(bc), .in_valid(vc), .clr_cnt(cc),
        .y(yc), .y_q(yqc), .eq_q(eqc), .out_valid(ovc), .eq_cnt(cntc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] walk [4];
    logic       walk_exp [4];

    initial begin
        walk[0] = 2'b00; walk[1] = 2'b01; walk[2] = 2'b10; walk[3] = 2'b11;
        walk_exp[0] = 1'b1; walk_exp[1] = 1'b0; walk_exp[2] = 1'b0; walk_exp[3] = 1'b1;

        // reset state
        #1;
        chk("rst_yq", {31'b0, yq1}, 32'd0);
        chk("rst_eq", {31'b0, eq1}, 32'd0);
        chk("rst_ov", {31'b0, ov1}, 32'd0);
        chk("rst_cnt", {24'b0, cnt1}, 32'd0);
        chk("rst_yq8", {24'b0, yq8}, 32'd0);

        // combinational truth table, independent of reset
        for (int i = 0; i < 4; i++) begin
            {a1, b1} = walk[i];
            #10;
            $display("t=%0t a=%b b=%b y=%b", $time, a1, b1, y1);
            chk("comb_tt", {31'b0, y1}, {31'b0, walk_exp[i]});
        end

        // release: the first edge afterwards must not capture
        @(negedge clk);
        rst_n = 1'b1;
        a1 = 1; b1 = 1; v1 = 1;
        tick();
        chk("rel_nocap_ov", {31'b0, ov1}, 32'd0);
        chk("rel_nocap_cnt", {24'b0, cnt1}, 32'd0);

        // walking pattern, 1-cycle latency
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            {a1, b1} = walk[i];
            tick();
            chk("walk_yq", {31'b0, yq1}, {31'b0, walk_exp[i]});
            chk("walk_eq", {31'b0, eq1}, {31'b0, walk_exp[i]});
            chk("walk_ov", {31'b0, ov1}, 32'd1);
        end
        @(negedge clk);
        v1 = 0;
        chk("walk_cnt", {24'b0, cnt1}, 32'd2);
        tick();
        chk("idle_ov", {31'b0, ov1}, 32'd0);
        chk("idle_yq_hold", {31'b0, yq1}, 32'd1);
        a1 = 0; b1 = 1;
        #1;
        chk("idle_y_track", {31'b0, y1}, 32'd0);
        chk("idle_yq_hold2", {31'b0, yq1}, 32'd1);
        chk("idle_eq_hold", {31'b0, eq1}, 32'd1);
        a1 = 1;
        #1;
        chk("idle_y_track2", {31'b0, y1}, 32'd1);

        // 8-bit operands
        @(negedge clk);
        a8 = 8'hA5; b8 = 8'hA5; v8 = 1;
        #1;
        chk("w8_y_eq", {24'b0, y8}, 32'h0000_00FF);
        tick();
        chk("w8_yq_eq", {24'b0, yq8}, 32'h0000_00FF);
        chk("w8_eqq_eq", {31'b0, eq8}, 32'd1);
        @(negedge clk);
        b8 = 8'h5A;
        #1;
        chk("w8_y_inv", {24'b0, y8}, 32'h0000_0000);
        tick();
        chk("w8_eqq_inv", {31'b0, eq8}, 32'd0);
        @(negedge clk);
        a8 = 8'hF0; b8 = 8'hFF;
        #1;
        chk("w8_y_mix", {24'b0, y8}, 32'h0000_00F0);
        tick();
        chk("w8_yq_mix", {24'b0, yq8}, 32'h0000_00F0);
        chk("w8_eqq_mix", {31'b0, eq8}, 32'd0);
        chk("w8_cnt", {24'b0, cnt8}, 32'd1);
        @(negedge clk);
        v8 = 0;

        // saturation with a 2-bit counter
        ac = 1; bc = 1; vc = 1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("sat_cnt", {30'b0, cntc}, (i > 3) ? 32'd3 : i);
        end
        @(negedge clk);
        cc = 1;
        tick();
        chk("clr_wins", {30'b0, cntc}, 32'd0);
        @(negedge clk);
        cc = 0;
        tick();
        chk("after_clr", {30'b0, cntc}, 32'd1);
        @(negedge clk);
        vc = 0;

        // asynchronous reset mid-stream
        a1 = 0; b1 = 0; v1 = 1;
        tick();
        chk("mid_ov_pre", {31'b0, ov1}, 32'd1);
        chk("mid_yq_pre", {31'b0, yq1}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_yq", {31'b0, yq1}, 32'd0);
        chk("mid_eq", {31'b0, eq1}, 32'd0);
        chk("mid_ov", {31'b0, ov1}, 32'd0);
        chk("mid_cnt", {24'b0, cnt1}, 32'd0);
        chk("mid_cntc", {30'b0, cntc}, 32'd0);
        tick();
        chk("hold_rst_ov", {31'b0, ov1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rel2_nocap_ov", {31'b0, ov1}, 32'd0);
        chk("rel2_nocap_yq", {31'b0, yq1}, 32'd0);
        tick();
        chk("rel2_cap_ov", {31'b0, ov1}, 32'd1);
        chk("rel2_cap_cnt", {24'b0, cnt1}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
